clause_walk_sequencer: RTL and testbench
========================================

Name: clause_walk_sequencer

Overview:
- Sits between the literal selector and the clause table. It drives the Address Translation Table (ATT) read port.
- For each accepted literal, it issues the ATT lookup, waits out the ATT's 1-cycle registered read, and latches the returned clause-table base address and clause mask.
- It then walks every set mask bit, lowest index first, emitting one clause-table read request per bit on a valid/ready interface.
- When the walk ends it signals completion to the control FSM.

Parameters:
- CLAUSE_COUNT, 20, width of ATT mask field (clause slots per literal)
- LITERAL_ADDRESS_WIDTH, 12, literal address width (ATT depth = 2**this)
- CLAUSE_TABLE_ADDRESS_WIDTH, 11, clause table address width
- SLOT_WIDTH, $clog2(CLAUSE_COUNT), slot index width (localparam, derived)

Ports:
- clk_i  in  1  clock, all logic on posedge
- rst_i  in  1  asynchronous, active-high reset
- lit_valid_i  in  1  literal request valid
- lit_ready_o  out  1  block can accept a literal (high only in IDLE)
- lit_addr_i  in  LITERAL_ADDRESS_WIDTH  literal address
- att_rd_addr_o  out  LITERAL_ADDRESS_WIDTH  ATT read address (registered)
- att_addr_i  in  CLAUSE_TABLE_ADDRESS_WIDTH  ATT base address output
- att_mask_i  in  CLAUSE_COUNT  ATT mask output
- ct_valid_o  out  1  clause-table request valid
- ct_ready_i  in  1  clause-table request accepted
- ct_addr_o  out  CLAUSE_TABLE_ADDRESS_WIDTH  clause-table address = base + slot
- ct_slot_o  out  SLOT_WIDTH  mask bit index of current request
- ct_last_o  out  1  current request is the final one for this literal
- done_o  out  1  1-cycle pulse, walk complete
- empty_o  out  1  valid with done_o: mask was all-zero
- count_o  out  SLOT_WIDTH+1  requests emitted for the last literal; valid with done_o, held until next accept
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE.
  - All outputs 0 except lit_ready_o=1.
  - Internal mask, base and count registers cleared.
  - Reset mid-walk aborts immediately: no done_o, no further ct_valid_o.
- States: IDLE, LOOKUP, CAPTURE, WALK, DONE.
- IDLE:
  - lit_ready_o=1.
  - On lit_valid_i&lit_ready_o: att_rd_addr_o<=lit_addr_i, count<=0, go LOOKUP.
- LOOKUP (1 cycle): the ATT samples att_rd_addr_o at the closing edge. Go CAPTURE.
- CAPTURE (1 cycle): latch base<=att_addr_i and mask<=att_mask_i at the closing edge.
  - If att_mask_i==0: go DONE with empty flag set.
  - Otherwise go WALK.
- att_rd_addr_o holds its value from accept until the next accept.
- WALK:
  - ct_valid_o=1.
  - ct_slot_o = index of the lowest set bit of the remaining mask.
  - ct_addr_o = (base + ct_slot_o) mod 2**CLAUSE_TABLE_ADDRESS_WIDTH. Wraps silently, no overflow flag.
  - ct_last_o=1 iff exactly one bit remains.
  - On ct_valid_o&ct_ready_i: clear that bit and increment count.
    - If ct_last_o, go DONE.
    - Otherwise stay in WALK; the next set bit is presented the following cycle.
  - While ct_ready_i=0, ct_addr_o, ct_slot_o and ct_last_o are stable. ct_valid_o is never dropped once raised.
  - Throughput: one request per cycle under continuous ct_ready_i.
- DONE (1 cycle): done_o=1, empty_o = mask-was-zero, count_o valid. Go IDLE.
- Latency: accept edge to first ct_valid_o = 3 cycles; accept edge to done_o with an empty mask = 3 cycles.
- Back-to-back literals: a new literal is accepted in the IDLE cycle immediately after DONE. No bubble beyond DONE.
- ct_ready_i asserted with ct_valid_o=0 is ignored.
- Changes on lit_valid_i or lit_addr_i outside IDLE are ignored.
- Mask bits at index >= CLAUSE_COUNT do not exist. A full mask (all CLAUSE_COUNT bits set) yields count_o=CLAUSE_COUNT.
- ATT writes during a walk do not affect the latched base/mask.

Test Plan:
- Basic walk: ATT[0x003]={base 0x010, mask 0b101}; accept lit 0x003, ct_ready_i=1 → ct_addr 0x010 (slot 0, last 0), then 0x012 (slot 2, last 1); done_o next cycle, count_o=2, empty_o=0; first ct_valid 3 cycles after accept.
- Empty mask: ATT[0x020]={0x100, 0} → no ct_valid_o; done_o=1, empty_o=1, count_o=0, 3 cycles after accept.
- Backpressure: mask 0b11, ct_ready_i low for 4 cycles on the first request → ct_addr/slot held stable, ct_valid_o stays high; then 2 handshakes, done_o, count_o=2.
- Wrap-around: base 0x7FF, mask 0b11 → ct_addr 0x7FF then 0x000.
- Full mask: mask=0xFFFFF, base 0x000 → 20 consecutive requests slots 0..19, ct_last_o only on slot 19, count_o=20.
- Reset mid-walk: assert rst_i after the 2nd of 5 handshakes → outputs 0, lit_ready_o=1 asynchronously, no done_o. A fresh literal afterwards walks correctly. Back-to-back: two literals fed with lit_valid_i held → second accepted the cycle after the first done_o.

Source files
------------

// File: rtl/clause_walk_sequencer.sv
// Clause walk sequencer: takes a literal, reads its entry from the ATT,
// then issues one clause-table request per set mask bit (lowest first),
// and pulses done_o when the walk completes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a literal; accept latches the ATT read address
// LOOKUP  | ATT samples att_rd_addr_o at the closing edge
// CAPTURE | ATT data valid; latch base and mask at the closing edge
// WALK    | present one clause-table request per remaining mask bit
// DONE    | one-cycle completion pulse with count/empty status
module clause_walk_sequencer #(
    parameter int CLAUSE_COUNT               = 20,
    parameter int LITERAL_ADDRESS_WIDTH      = 12,
    parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11,
    localparam int SLOT_WIDTH                = $clog2(CLAUSE_COUNT)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  lit_valid_i,
    output logic                                  lit_ready_o,
    input  logic [LITERAL_ADDRESS_WIDTH-1:0]      lit_addr_i,
    output logic [LITERAL_ADDRESS_WIDTH-1:0]      att_rd_addr_o,
    input  logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] att_addr_i,
    input  logic [CLAUSE_COUNT-1:0]               att_mask_i,
    output logic                                  ct_valid_o,
    input  logic                                  ct_ready_i,
    output logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] ct_addr_o,
    output logic [SLOT_WIDTH-1:0]                 ct_slot_o,
    output logic                                  ct_last_o,
    output logic                                  done_o,
    output logic                                  empty_o,
    output logic [SLOT_WIDTH:0]                   count_o,
    output logic                                  busy_o
);

    localparam int CNT_W = SLOT_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CAPTURE,
        S_WALK,
        S_DONE
    } state_t;

    state_t                                state_q, state_d;
    logic [LITERAL_ADDRESS_WIDTH-1:0]      att_rd_addr_q, att_rd_addr_d;
    logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] base_q, base_d;
    logic [CLAUSE_COUNT-1:0]               mask_q, mask_d;
    logic [CNT_W-1:0]                      count_q, count_d;

    logic [SLOT_WIDTH-1:0]                 slot_c;
    logic                                  last_c;
    logic [CLAUSE_COUNT-1:0]               mask_rest_c;

    // Lowest set bit of the remaining mask, and the mask with that bit removed
    always_comb begin
        slot_c = '0;
        for (int i = CLAUSE_COUNT - 1; i >= 0; i--) begin
            if (mask_q[i]) slot_c = SLOT_WIDTH'(i);
        end
        mask_rest_c = mask_q & (mask_q - CLAUSE_COUNT'(1));
        last_c      = (mask_rest_c == '0);
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (lit_valid_i) state_d = S_LOOKUP;
            S_LOOKUP:  state_d = S_CAPTURE;
            S_CAPTURE: state_d = (att_mask_i == '0) ? S_DONE : S_WALK;
            S_WALK:    if (ct_ready_i && last_c) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath next values: ATT address, latched ATT entry, request count
    always_comb begin
        att_rd_addr_d = att_rd_addr_q;
        base_d        = base_q;
        mask_d        = mask_q;
        count_d       = count_q;
        case (state_q)
            S_IDLE: begin
                if (lit_valid_i) begin
                    att_rd_addr_d = lit_addr_i;
                    count_d       = '0;
                end
            end
            S_CAPTURE: begin
                base_d = att_addr_i;
                mask_d = att_mask_i;
            end
            S_WALK: begin
                if (ct_ready_i) begin
                    mask_d  = mask_rest_c;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            att_rd_addr_q <= '0;
            base_q        <= '0;
            mask_q        <= '0;
            count_q       <= '0;
        end else begin
            att_rd_addr_q <= att_rd_addr_d;
            base_q        <= base_d;
            mask_q        <= mask_d;
            count_q       <= count_d;
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        lit_ready_o = 1'b0;
        busy_o      = 1'b1;
        ct_valid_o  = 1'b0;
        ct_addr_o   = '0;
        ct_slot_o   = '0;
        ct_last_o   = 1'b0;
        done_o      = 1'b0;
        empty_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                lit_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            S_WALK: begin
                ct_valid_o = 1'b1;
                ct_slot_o  = slot_c;
                ct_addr_o  = base_q + CLAUSE_TABLE_ADDRESS_WIDTH'(slot_c);
                ct_last_o  = last_c;
            end
            S_DONE: begin
                done_o  = 1'b1;
                // A non-empty mask always produces at least one request
                empty_o = (count_q == '0);
            end
            default: ;
        endcase
    end

    assign att_rd_addr_o = att_rd_addr_q;
    assign count_o       = count_q;

endmodule

// File: tb/tb_clause_walk_sequencer.sv
// Directed bench for clause_walk_sequencer with a registered-read ATT model.
module tb_clause_walk_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        lit_valid;
    logic        lit_ready_o;
    logic [11:0] lit_addr;
    logic [11:0] att_rd_addr_o;
    logic [10:0] att_addr;
    logic [19:0] att_mask;
    logic        ct_valid_o;
    logic        ct_ready;
    logic [10:0] ct_addr_o;
    logic [4:0]  ct_slot_o;
    logic        ct_last_o;
    logic        done_o;
    logic        empty_o;
    logic [5:0]  count_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] base_mem [4096];
    logic [19:0] mask_mem [4096];

    typedef struct {
        logic [11:0] lit;
        logic [10:0] base;
        logic [19:0] mask;
        int          stall;
        int          exp_count;
        logic        exp_empty;
        logic [10:0] exp_first;
        logic [10:0] exp_last;
    } vec_t;

    vec_t vecs [7];

    clause_walk_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .lit_valid_i  (lit_valid),
        .lit_ready_o  (lit_ready_o),
        .lit_addr_i   (lit_addr),
        .att_rd_addr_o(att_rd_addr_o),
        .att_addr_i   (att_addr),
        .att_mask_i   (att_mask),
        .ct_valid_o   (ct_valid_o),
        .ct_ready_i   (ct_ready),
        .ct_addr_o    (ct_addr_o),
        .ct_slot_o    (ct_slot_o),
        .ct_last_o    (ct_last_o),
        .done_o       (done_o),
        .empty_o      (empty_o),
        .count_o      (count_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // ATT model: one-cycle registered read
    always @(posedge clk) begin
        att_addr <= base_mem[att_rd_addr_o];
        att_mask <= mask_mem[att_rd_addr_o];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lowest(input logic [19:0] m);
        int r = 0;
        for (int i = 19; i >= 0; i--) if (m[i]) r = i;
        return r;
    endfunction

    // Accept one literal from IDLE and follow the walk to DONE (called at a negedge)
    task automatic run_vec(input vec_t v);
        logic [19:0] rem;
        logic [10:0] first_a, last_a;
        int          n, last_hs, stall_left, s;
        bit          first_seen, got_done;
        rem = v.mask; n = 0; last_hs = -10; stall_left = v.stall;
        first_seen = 0; got_done = 0; first_a = '0; last_a = '0;
        check("lit_ready_idle", lit_ready_o, 1);
        lit_valid = 1'b1; lit_addr = v.lit; ct_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        lit_valid = 1'b0; lit_addr = 12'hFFF;
        check("att_rd_addr", att_rd_addr_o, v.lit);
        check("busy_after_accept", busy_o, 1);
        for (int c = 1; c <= 60 && !got_done; c++) begin
            if (ct_valid_o) begin
                if (!first_seen) begin
                    check("first_valid_latency", c, 3);
                    first_seen = 1;
                end
                if (rem == '0) begin
                    check("extra_request", ct_valid_o, 0);
                end else begin
                    s = lowest(rem);
                    check("ct_slot", ct_slot_o, s);
                    check("ct_addr", ct_addr_o, 11'(v.base + 11'(s)));
                    check("ct_last", ct_last_o, ((rem & (rem - 20'd1)) == '0));
                    if (stall_left > 0) begin
                        ct_ready = 1'b0;
                        stall_left--;
                        mask_mem[v.lit] = '0;
                        base_mem[v.lit] = 11'h7AA;
                    end else begin
                        ct_ready = 1'b1;
                        if (n == 0) first_a = ct_addr_o;
                        last_a  = ct_addr_o;
                        rem     = rem & (rem - 20'd1);
                        n++;
                        last_hs = c;
                    end
                end
            end else begin
                ct_ready = 1'b1;
                if (first_seen && rem != '0) check("valid_dropped", ct_valid_o, 1);
            end
            if (done_o) begin
                got_done = 1;
                check("done_count", count_o, v.exp_count);
                check("done_empty", empty_o, v.exp_empty);
                if (v.exp_empty) check("empty_latency", c, 3);
                else             check("done_after_last", c, last_hs + 1);
            end
            @(posedge clk); @(negedge clk);
        end
        if (!got_done) check("done_timeout", 0, 1);
        if (!v.exp_empty) begin
            check("first_addr", first_a, v.exp_first);
            check("last_addr", last_a, v.exp_last);
        end
        check("count_held", count_o, v.exp_count);
        check("done_pulse_width", done_o, 0);
    endtask

    initial begin
        bit got;
        int cyc;
        vecs[0] = '{12'h003, 11'h010, 20'h00005, 0, 2,  1'b0, 11'h010, 11'h012};
        vecs[1] = '{12'h020, 11'h100, 20'h00000, 0, 0,  1'b1, 11'h000, 11'h000};
        vecs[2] = '{12'h044, 11'h020, 20'h00003, 4, 2,  1'b0, 11'h020, 11'h021};
        vecs[3] = '{12'h7FF, 11'h7FF, 20'h00003, 0, 2,  1'b0, 11'h7FF, 11'h000};
        vecs[4] = '{12'h100, 11'h000, 20'hFFFFF, 0, 20, 1'b0, 11'h000, 11'h013};
        vecs[5] = '{12'hABC, 11'h3F0, 20'h80001, 0, 2,  1'b0, 11'h3F0, 11'h403};
        vecs[6] = '{12'h555, 11'h555, 20'h00400, 0, 1,  1'b0, 11'h55F, 11'h55F};
        for (int i = 0; i < 4096; i++) begin
            base_mem[i] = '0;
            mask_mem[i] = '0;
        end
        for (int i = 0; i < 7; i++) begin
            base_mem[vecs[i].lit] = vecs[i].base;
            mask_mem[vecs[i].lit] = vecs[i].mask;
        end
        base_mem[12'h0F0] = 11'h200;
        mask_mem[12'h0F0] = 20'h0001F;

        rst = 1'b1; lit_valid = 1'b0; lit_addr = '0; ct_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lit_ready", lit_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_ct_valid", ct_valid_o, 0);
        check("rst_done", done_o, 0);
        check("rst_count", count_o, 0);
        check("rst_att_addr", att_rd_addr_o, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of a five-request walk
        lit_valid = 1'b1; lit_addr = 12'h0F0; ct_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        lit_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (ct_valid_o) got = 1;
            else begin @(posedge clk); @(negedge clk); end
        end
        check("midrst_first_valid", got, 1);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("midrst_count_before", count_o, 2);
        check("midrst_slot_before", ct_slot_o, 2);
        rst = 1'b1;
        #1;
        check("midrst_lit_ready", lit_ready_o, 1);
        check("midrst_ct_valid", ct_valid_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_count", count_o, 0);
        check("midrst_att_addr", att_rd_addr_o, 0);
        ct_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        got = 0;
        for (int c = 0; c < 6; c++) begin
            if (done_o || ct_valid_o) got = 1;
            @(posedge clk); @(negedge clk);
        end
        check("midrst_no_activity", got, 0);
        run_vec(vecs[0]);

        // Back-to-back literals with lit_valid held
        lit_valid = 1'b1; lit_addr = 12'h003; ct_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); @(negedge clk);
            if (done_o) got = 1;
        end
        check("b2b_first_done", got, 1);
        check("b2b_first_count", count_o, 2);
        check("b2b_ready_in_done", lit_ready_o, 0);
        lit_addr = 12'h020;
        @(posedge clk); @(negedge clk);
        check("b2b_ready_after_done", lit_ready_o, 1);
        @(posedge clk); @(negedge clk);
        lit_valid = 1'b0;
        check("b2b_second_accepted", busy_o, 1);
        check("b2b_second_addr", att_rd_addr_o, 12'h020);
        got = 0; cyc = 0;
        for (int c = 1; c < 10 && !got; c++) begin
            if (done_o) begin got = 1; cyc = c; end
            else begin @(posedge clk); @(negedge clk); end
        end
        check("b2b_second_latency", cyc, 3);
        check("b2b_second_empty", empty_o, 1);
        check("b2b_second_count", count_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
